// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file sequencer.
// State encoding, read/write strobe values and default widths.
package regfile_seq_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int COUNT_W = 8;

  localparam logic RF_READ  = 1'b0;
  localparam logic RF_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    ISSUE,
    WAIT,
    WRITE
  } state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Register-op sequencer: read two operands, issue them to a unit,
// write the result back. Ports: Req*, RF (A/B/DAddress, DData,
// ReadOrWrite, AData, BData), Op*, Res*, OpCount.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int COUNT_WIDTH = COUNT_W
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic [ADDR_WIDTH-1:0]  ReqAAddr,
  input  logic [ADDR_WIDTH-1:0]  ReqBAddr,
  input  logic [ADDR_WIDTH-1:0]  ReqDAddr,
  input  logic                   ReqWrBack,
  output logic [ADDR_WIDTH-1:0]  AAddress,
  output logic [ADDR_WIDTH-1:0]  BAddress,
  output logic [ADDR_WIDTH-1:0]  DAddress,
  output logic [DATA_WIDTH-1:0]  DData,
  output logic                   ReadOrWrite,
  input  logic [DATA_WIDTH-1:0]  AData,
  input  logic [DATA_WIDTH-1:0]  BData,
  output logic                   OpValid,
  input  logic                   OpReady,
  output logic [DATA_WIDTH-1:0]  OpA,
  output logic [DATA_WIDTH-1:0]  OpB,
  input  logic                   ResValid,
  output logic                   ResReady,
  input  logic [DATA_WIDTH-1:0]  ResData,
  output logic [COUNT_WIDTH-1:0] OpCount
);

  state_t state;
  logic   wr_back;

  // Gated by ResetN so the port reads 0 for the whole reset
  // and 1 immediately once reset is released.
  assign ReqReady = ResetN && (state == IDLE);

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state       <= IDLE;
      wr_back     <= 1'b0;
      AAddress    <= '0;
      BAddress    <= '0;
      DAddress    <= '0;
      DData       <= '0;
      ReadOrWrite <= RF_READ;
      OpValid     <= 1'b0;
      OpA         <= '0;
      OpB         <= '0;
      ResReady    <= 1'b0;
      OpCount     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            AAddress <= ReqAAddr;
            BAddress <= ReqBAddr;
            DAddress <= ReqDAddr;
            wr_back  <= ReqWrBack;
            state    <= READ;
          end
        end
        READ: begin
          OpA     <= AData;
          OpB     <= BData;
          OpValid <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          if (OpValid && OpReady) begin
            OpValid  <= 1'b0;
            ResReady <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (ResValid && ResReady) begin
            DData    <= ResData;
            ResReady <= 1'b0;
            if (wr_back) begin
              ReadOrWrite <= RF_WRITE;
              state       <= WRITE;
            end else begin
              OpCount <= OpCount + COUNT_WIDTH'(1);
              state   <= IDLE;
            end
          end
        end
        WRITE: begin
          ReadOrWrite <= RF_READ;
          OpCount     <= OpCount + COUNT_WIDTH'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer with a behavioural
// register file, vector table, hand sequences and random ops.
module tb_regfile_sequencer;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  ReqAAddr, ReqBAddr, ReqDAddr;
  logic        ReqWrBack;
  logic [2:0]  AAddress, BAddress, DAddress;
  logic [15:0] DData;
  logic        ReadOrWrite;
  logic [15:0] AData, BData;
  logic        OpValid, OpReady;
  logic [15:0] OpA, OpB;
  logic        ResValid, ResReady;
  logic [15:0] ResData;
  logic [7:0]  OpCount;

  regfile_sequencer dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAAddr(ReqAAddr), .ReqBAddr(ReqBAddr),
    .ReqDAddr(ReqDAddr), .ReqWrBack(ReqWrBack),
    .AAddress(AAddress), .BAddress(BAddress),
    .DAddress(DAddress), .DData(DData),
    .ReadOrWrite(ReadOrWrite),
    .AData(AData), .BData(BData),
    .OpValid(OpValid), .OpReady(OpReady),
    .OpA(OpA), .OpB(OpB),
    .ResValid(ResValid), .ResReady(ResReady),
    .ResData(ResData), .OpCount(OpCount)
  );

  always #5 Clock = ~Clock;

  // Behavioural 8x16 register file with a preload port.
  logic [15:0] rf [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          wr_count = 0;

  assign AData = rf[AAddress];
  assign BData = rf[BAddress];

  always @(posedge Clock) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (ReadOrWrite) begin
      rf[DAddress] <= DData;
      wr_count     <= wr_count + 1;
    end
  end

  // Reference state.
  logic [15:0] ref_rf [8];
  logic [7:0]  exp_count;
  int          total_ops;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic rf_compare(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (rf[i] !== ref_rf[i]) bad++;
    chk({tag, ":rf_contents_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic txn(input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] d, input logic wb,
                     input int opd, input int resd,
                     input logic [15:0] ea, input logic [15:0] eb,
                     input logic [15:0] res, input string tag);
    int n;
    int w0;
    n = 0;
    @(negedge Clock);
    while (!ReqReady && n < 10) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, ":req_ready"}, 32'(ReqReady), 32'd1);
    if (!ReqReady) return;
    w0 = wr_count;
    ReqValid = 1'b1;
    ReqAAddr = a;
    ReqBAddr = b;
    ReqDAddr = d;
    ReqWrBack = wb;
    @(negedge Clock);
    ReqValid = 1'b0;
    ReqAAddr = 3'($urandom);
    ReqBAddr = 3'($urandom);
    ReqDAddr = 3'($urandom);
    ReqWrBack = 1'($urandom);
    chk({tag, ":read_addrs"}, {23'd0, AAddress, BAddress, DAddress},
        {23'd0, a, b, d});
    chk({tag, ":read_opvalid_rw"}, {30'd0, OpValid, ReadOrWrite}, 32'd0);
    @(negedge Clock);
    chk({tag, ":issue_opvalid"}, 32'(OpValid), 32'd1);
    chk({tag, ":issue_ops"}, {OpA, OpB}, {ea, eb});
    repeat (opd) begin
      @(negedge Clock);
      chk({tag, ":issue_hold"},
          {13'd0, OpValid, ResReady, ReadOrWrite, OpA ^ OpB},
          {13'd0, 1'b1, 1'b0, 1'b0, ea ^ eb});
    end
    OpReady = 1'b1;
    ResValid = 1'b1;
    ResData = ~res;
    @(negedge Clock);
    OpReady = 1'b0;
    ResValid = 1'b0;
    chk({tag, ":wait_flags"}, {30'd0, OpValid, ResReady}, 32'd1);
    repeat (resd) begin
      @(negedge Clock);
      chk({tag, ":wait_hold"}, {30'd0, ResReady, ReadOrWrite}, 32'd2);
    end
    ResValid = 1'b1;
    ResData = res;
    @(negedge Clock);
    ResValid = 1'b0;
    chk({tag, ":ddata"}, 32'(DData), 32'(res));
    chk({tag, ":resready_low"}, 32'(ResReady), 32'd0);
    if (wb) begin
      chk({tag, ":write_cycle"}, {28'd0, ReadOrWrite, DAddress},
          {28'd0, 1'b1, d});
      @(negedge Clock);
    end
    chk({tag, ":done_rw_rdy"}, {30'd0, ReadOrWrite, ReqReady}, 32'd1);
    if (wb) ref_rf[d] = res;
    exp_count = exp_count + 8'd1;
    total_ops++;
    chk({tag, ":opcount"}, 32'(OpCount), 32'(exp_count));
    chk({tag, ":writes"}, 32'(wr_count - w0), 32'(wb));
    rf_compare(tag);
  endtask

  typedef struct {
    logic [2:0]  a, b, d;
    logic        wb;
    int          opd, resd;
    logic [15:0] ea, eb, res;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pre [8];
    logic [2:0] a, b, d;
    logic wb;
    logic [15:0] r;
    int w0;

    ResetN = 1'b0;
    ReqValid = 1'b0;
    ReqAAddr = '0;
    ReqBAddr = '0;
    ReqDAddr = '0;
    ReqWrBack = 1'b0;
    OpReady = 1'b0;
    ResValid = 1'b0;
    ResData = '0;
    exp_count = '0;
    total_ops = 0;

    pre[0] = 16'h0000; pre[1] = 16'h1111;
    pre[2] = 16'h1234; pre[3] = 16'h0001;
    pre[4] = 16'hA5A5; pre[5] = 16'h00FF;
    pre[6] = 16'h8000; pre[7] = 16'h0000;

    // T1: preload during reset, all outputs held at zero.
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      pre_en = 1'b1;
      pre_addr = 3'(i);
      pre_data = pre[i];
      ref_rf[i] = pre[i];
    end
    @(negedge Clock);
    pre_en = 1'b0;
    @(negedge Clock);
    chk("reset_addrs", {23'd0, AAddress, BAddress, DAddress}, 32'd0);
    chk("reset_data", {OpA ^ OpB, DData}, 32'd0);
    chk("reset_ctrl",
        {26'd0, ReqReady, ReadOrWrite, OpValid, ResReady, 2'b00},
        32'd0);
    chk("reset_count", 32'(OpCount), 32'd0);
    chk("reset_opab", {OpA, OpB}, 32'd0);
    ResetN = 1'b1;
    #1;
    chk("release_reqready", 32'(ReqReady), 32'd1);

    // T6: reset while in ISSUE aborts with no write.
    w0 = wr_count;
    ReqValid = 1'b1;
    ReqAAddr = 3'd1;
    ReqBAddr = 3'd2;
    ReqDAddr = 3'd3;
    ReqWrBack = 1'b1;
    @(negedge Clock);
    ReqValid = 1'b0;
    @(negedge Clock);
    chk("abort_in_issue", 32'(OpValid), 32'd1);
    ResetN = 1'b0;
    ResValid = 1'b1;
    ResData = 16'hDEAD;
    @(negedge Clock);
    chk("abort_ctrl",
        {28'd0, ReqReady, ReadOrWrite, OpValid, ResReady}, 32'd0);
    chk("abort_count", 32'(OpCount), 32'd0);
    ResetN = 1'b1;
    OpReady = 1'b1;
    repeat (4) @(negedge Clock);
    chk("abort_idle", {30'd0, ReqReady, OpValid}, 32'd2);
    OpReady = 1'b0;
    ResValid = 1'b0;
    chk("abort_no_write", 32'(wr_count - w0), 32'd0);
    chk("abort_count_after", 32'(OpCount), 32'd0);
    rf_compare("abort");

    // Directed vector table (T2..T5 and follow-ups).
    vecs[0] = '{3'd2, 3'd5, 3'd7, 1'b1, 0, 0,
                16'h1234, 16'h00FF, 16'h1333};
    vecs[1] = '{3'd7, 3'd1, 3'd4, 1'b0, 0, 0,
                16'h1333, 16'h1111, 16'hBEEF};
    vecs[2] = '{3'd4, 3'd6, 3'd0, 1'b1, 3, 4,
                16'hA5A5, 16'h8000, 16'h5A5A};
    vecs[3] = '{3'd3, 3'd3, 3'd3, 1'b1, 0, 0,
                16'h0001, 16'h0001, 16'h0002};
    vecs[4] = '{3'd0, 3'd3, 3'd6, 1'b1, 1, 2,
                16'h5A5A, 16'h0002, 16'h5A5C};
    vecs[5] = '{3'd6, 3'd6, 3'd6, 1'b1, 0, 1,
                16'h5A5C, 16'h5A5C, 16'hB4B8};
    for (int i = 0; i < 6; i++)
      txn(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].wb,
          vecs[i].opd, vecs[i].resd,
          vecs[i].ea, vecs[i].eb, vecs[i].res,
          $sformatf("vec%0d", i));

    // Random ops against the reference model, through the wrap.
    while (total_ops < 260) begin
      a = 3'($urandom);
      b = 3'($urandom);
      d = 3'($urandom);
      wb = 1'($urandom);
      if ($urandom_range(0, 1) == 1) r = ref_rf[a] + ref_rf[b];
      else r = 16'($urandom);
      txn(a, b, d, wb, $urandom_range(0, 2), $urandom_range(0, 2),
          ref_rf[a], ref_rf[b], r, $sformatf("rnd%0d", total_ops));
      if (total_ops == 256)
        chk("opcount_wrap", 32'(OpCount), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
